// File: rtl/axi_lite_bus_monitor_if.sv
// Tap bundle for one AXI4-Lite link. The bench or SoC wrapper drives it through
// the master modport, and the monitor only ever observes it through the slave modport.
interface axi_lite_bus_monitor_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mon_arvalid, mon_arready;
  logic [ADDR_W-1:0] mon_araddr;
  logic              mon_rvalid, mon_rready;
  logic [DATA_W-1:0] mon_rdata;
  logic              mon_awvalid, mon_awready;
  logic [ADDR_W-1:0] mon_awaddr;
  logic              mon_wvalid, mon_wready;
  logic [DATA_W-1:0] mon_wdata;
  logic              mon_bvalid, mon_bready;

  modport master (
    output mon_arvalid, mon_arready, mon_araddr,
    output mon_rvalid, mon_rready, mon_rdata,
    output mon_awvalid, mon_awready, mon_awaddr,
    output mon_wvalid, mon_wready, mon_wdata,
    output mon_bvalid, mon_bready
  );

  modport slave (
    input mon_arvalid, mon_arready, mon_araddr,
    input mon_rvalid, mon_rready, mon_rdata,
    input mon_awvalid, mon_awready, mon_awaddr,
    input mon_wvalid, mon_wready, mon_wdata,
    input mon_bvalid, mon_bready
  );
endinterface

// File: rtl/axi_lite_bus_monitor.sv
// Passive AXI4-Lite link monitor: it counts transfers, tracks outstanding requests,
// captures the first read and the first trap, latches the first protocol error and runs an idle watchdog.

// Per-channel stability and stall checker for the VALID/READY source channels (AR, AW, W).
module axi_lite_chan_chk #(
  parameter int PW          = 32,
  parameter int STALL_LIMIT = 256
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          clr,
  input  logic          valid,
  input  logic          ready,
  input  logic [PW-1:0] payload,
  output logic          unstable,
  output logic          stall
);
  localparam int SW = $clog2(STALL_LIMIT + 1);

  logic          pend;
  logic [PW-1:0] pay_q;
  logic [SW-1:0] stall_cnt;
  logic          waiting;

  assign waiting  = valid && !ready;
  assign unstable = pend && (!valid || payload != pay_q);
  assign stall    = waiting && (stall_cnt == SW'(STALL_LIMIT - 1));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pend      <= 1'b0;
      pay_q     <= '0;
      stall_cnt <= '0;
    end else if (clr) begin
      pend      <= 1'b0;
      pay_q     <= '0;
      stall_cnt <= '0;
    end else begin
      pend  <= waiting;
      pay_q <= payload;
      // The counter parks at the limit so a long stall keeps reporting without wrapping.
      if (!waiting)   stall_cnt <= '0;
      else if (!stall) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

module axi_lite_bus_monitor #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int CNT_W          = 16,
  parameter int OUTST_W        = 4,
  parameter int STALL_LIMIT    = 256,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 clr,
  axi_lite_bus_monitor_if.slave mon,
  input  logic                 cpu_trap,
  output logic [CNT_W-1:0]     rd_count,
  output logic [CNT_W-1:0]     wr_count,
  output logic                 first_rd_valid,
  output logic [ADDR_W-1:0]    first_rd_addr,
  output logic [DATA_W-1:0]    first_rd_data,
  output logic                 trap_seen,
  output logic [31:0]          trap_cycle,
  output logic                 err_valid,
  output logic [2:0]           err_code,
  output logic                 timeout,
  output logic [1:0]           wd_state
);
  localparam int PW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [OUTST_W-1:0] OMAX = '1;

  typedef struct packed {
    logic [31:0]        cyc_count;
    logic [CNT_W-1:0]   rd_count;
    logic [CNT_W-1:0]   wr_count;
    logic [OUTST_W-1:0] rd_out;
    logic [OUTST_W-1:0] wr_out;
    logic               first_ar_seen;
    logic               first_rd_valid;
    logic [ADDR_W-1:0]  first_rd_addr;
    logic [DATA_W-1:0]  first_rd_data;
    logic               trap_seen;
    logic [31:0]        trap_cycle;
    logic               err_valid;
    logic [2:0]         err_code;
  } mon_state_t;

  typedef enum logic [1:0] {
    WD_ARMED   = 2'd0,
    WD_ACTIVE  = 2'd1,
    WD_TIMEOUT = 2'd2
  } wd_t;

  mon_state_t         st, nxt;
  wd_t                wd;
  logic [IW-1:0]      idle_cnt;
  logic [OUTST_W-1:0] rd_out, wr_out, rd_out_nxt, wr_out_nxt;
  logic               ar_hs, r_hs, aw_hs, w_hs, b_hs, any_hs;
  logic               r_orphan, b_orphan, rd_ovf, wr_ovf;
  logic [7:1]         err_vec;
  logic [2:0]         err_nxt;

  logic [2:0]         ch_valid, ch_ready, ch_unstable, ch_stall;
  logic [2:0][PW-1:0] ch_pay;

  assign ar_hs  = mon.mon_arvalid && mon.mon_arready;
  assign r_hs   = mon.mon_rvalid  && mon.mon_rready;
  assign aw_hs  = mon.mon_awvalid && mon.mon_awready;
  assign w_hs   = mon.mon_wvalid  && mon.mon_wready;
  assign b_hs   = mon.mon_bvalid  && mon.mon_bready;
  assign any_hs = ar_hs || r_hs || aw_hs || w_hs || b_hs;

  // Channel index 0 = AR, 1 = AW, 2 = W, so ch_unstable[i] maps to error code i+1.
  assign ch_valid  = {mon.mon_wvalid, mon.mon_awvalid, mon.mon_arvalid};
  assign ch_ready  = {mon.mon_wready, mon.mon_awready, mon.mon_arready};
  assign ch_pay[0] = PW'(mon.mon_araddr);
  assign ch_pay[1] = PW'(mon.mon_awaddr);
  assign ch_pay[2] = PW'(mon.mon_wdata);

  for (genvar c = 0; c < 3; c++) begin : g_chan
    axi_lite_chan_chk #(.PW(PW), .STALL_LIMIT(STALL_LIMIT)) u_chk (
      .aclk     (aclk),
      .areset   (areset),
      .clr      (clr),
      .valid    (ch_valid[c]),
      .ready    (ch_ready[c]),
      .payload  (ch_pay[c]),
      .unstable (ch_unstable[c]),
      .stall    (ch_stall[c])
    );
  end

  // A same-cycle request and response cancel out, so neither orphan nor overflow applies.
  always_comb begin
    rd_out_nxt = st.rd_out;
    wr_out_nxt = st.wr_out;
    r_orphan   = 1'b0;
    b_orphan   = 1'b0;
    rd_ovf     = 1'b0;
    wr_ovf     = 1'b0;
    if (ar_hs && !r_hs) begin
      if (st.rd_out == OMAX) rd_ovf = 1'b1;
      else                   rd_out_nxt = st.rd_out + 1'b1;
    end else if (r_hs && !ar_hs) begin
      if (st.rd_out == '0) r_orphan = 1'b1;
      else                 rd_out_nxt = st.rd_out - 1'b1;
    end
    if (aw_hs && !b_hs) begin
      if (st.wr_out == OMAX) wr_ovf = 1'b1;
      else                   wr_out_nxt = st.wr_out + 1'b1;
    end else if (b_hs && !aw_hs) begin
      if (st.wr_out == '0) b_orphan = 1'b1;
      else                 wr_out_nxt = st.wr_out - 1'b1;
    end
  end

  assign err_vec = {|ch_stall, rd_ovf || wr_ovf, b_orphan, r_orphan, ch_unstable};

  always_comb begin
    err_nxt = 3'd0;
    for (int i = 7; i >= 1; i--)
      if (err_vec[i]) err_nxt = 3'(i);
  end

  always_comb begin
    nxt           = st;
    nxt.cyc_count = st.cyc_count + 32'd1;
    nxt.rd_out    = rd_out_nxt;
    nxt.wr_out    = wr_out_nxt;
    if (r_hs && st.rd_count != '1) nxt.rd_count = st.rd_count + 1'b1;
    if (b_hs && st.wr_count != '1) nxt.wr_count = st.wr_count + 1'b1;
    if (ar_hs && !st.first_ar_seen) begin
      nxt.first_ar_seen = 1'b1;
      nxt.first_rd_addr = mon.mon_araddr;
    end
    if (r_hs && !st.first_rd_valid) begin
      nxt.first_rd_valid = 1'b1;
      nxt.first_rd_data  = mon.mon_rdata;
    end
    if (cpu_trap && !st.trap_seen) begin
      nxt.trap_seen  = 1'b1;
      nxt.trap_cycle = st.cyc_count;
    end
    if (!st.err_valid && err_nxt != 3'd0) begin
      nxt.err_valid = 1'b1;
      nxt.err_code  = err_nxt;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)   st <= '0;
    else if (clr) st <= '0;
    else          st <= nxt;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wd       <= WD_ARMED;
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else if (clr) begin
      wd       <= WD_ARMED;
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      case (wd)
        WD_ARMED, WD_ACTIVE: begin
          if (any_hs) begin
            idle_cnt <= '0;
            wd       <= WD_ACTIVE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
            if (idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
              wd      <= WD_TIMEOUT;
              timeout <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_out         = st.rd_out;
  assign wr_out         = st.wr_out;
  assign rd_count       = st.rd_count;
  assign wr_count       = st.wr_count;
  assign first_rd_valid = st.first_rd_valid;
  assign first_rd_addr  = st.first_rd_addr;
  assign first_rd_data  = st.first_rd_data;
  assign trap_seen      = st.trap_seen;
  assign trap_cycle     = st.trap_cycle;
  assign err_valid      = st.err_valid;
  assign err_code       = st.err_code;
  assign wd_state       = wd;
endmodule

// File: tb/tb_axi_lite_bus_monitor.sv
// Bench for axi_lite_bus_monitor: directed scenarios plus randomized protocol-legal traffic
// checked against a transaction-level reference model.
module tb_axi_lite_bus_monitor;
  logic        aclk = 1'b0;
  logic        areset, clr, cpu_trap;
  logic [15:0] rd_count, wr_count;
  logic        first_rd_valid, trap_seen, err_valid, timeout;
  logic [31:0] first_rd_addr, first_rd_data, trap_cycle;
  logic [2:0]  err_code;
  logic [1:0]  wd_state;
  int          checks = 0;
  int          errors = 0;

  axi_lite_bus_monitor_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_lite_bus_monitor #(
    .ADDR_W(32), .DATA_W(32), .CNT_W(16), .OUTST_W(4),
    .STALL_LIMIT(8), .TIMEOUT_CYCLES(100)
  ) dut (
    .aclk(aclk), .areset(areset), .clr(clr), .mon(bus), .cpu_trap(cpu_trap),
    .rd_count(rd_count), .wr_count(wr_count), .first_rd_valid(first_rd_valid),
    .first_rd_addr(first_rd_addr), .first_rd_data(first_rd_data),
    .trap_seen(trap_seen), .trap_cycle(trap_cycle), .err_valid(err_valid),
    .err_code(err_code), .timeout(timeout), .wd_state(wd_state)
  );

  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_bus();
    bus.mon_arvalid = 0; bus.mon_arready = 0; bus.mon_araddr = '0;
    bus.mon_rvalid  = 0; bus.mon_rready  = 0; bus.mon_rdata  = '0;
    bus.mon_awvalid = 0; bus.mon_awready = 0; bus.mon_awaddr = '0;
    bus.mon_wvalid  = 0; bus.mon_wready  = 0; bus.mon_wdata  = '0;
    bus.mon_bvalid  = 0; bus.mon_bready  = 0;
    cpu_trap = 0;
  endtask

  task automatic do_clr();
    clr = 1; step(); clr = 0;
  endtask

  // Called just after a clock edge; the release happens well before the next edge.
  task automatic do_reset();
    areset = 1; #2; areset = 0;
  endtask

  task automatic test_reset();
    idle_bus(); clr = 0; areset = 1;
    #3;
    checks++;
    if ({rd_count, wr_count, first_rd_valid, first_rd_addr, first_rd_data, trap_seen,
         trap_cycle, err_valid, err_code, timeout, wd_state} !== '0) begin
      errors++; $display("FAIL reset_outputs rd=%0d wr=%0d err=%0d wd=%0d want all zero",
                         rd_count, wr_count, err_code, wd_state);
    end
    step(); areset = 0;
  endtask

  task automatic test_single_read();
    do_clr();
    bus.mon_arvalid = 1; bus.mon_arready = 1; bus.mon_araddr = 32'h0;
    step();
    bus.mon_arvalid = 0; bus.mon_arready = 0;
    checks++;
    if (first_rd_valid !== 1'b0 || rd_count !== 16'd0) begin
      errors++; $display("FAIL rd_after_ar valid=%0b cnt=%0d want 0 0", first_rd_valid, rd_count);
    end
    step();
    bus.mon_rvalid = 1; bus.mon_rready = 1; bus.mon_rdata = 32'h13;
    step();
    bus.mon_rvalid = 0; bus.mon_rready = 0;
    checks++;
    if (rd_count !== 16'd1) begin errors++; $display("FAIL rd_count got %0d want 1", rd_count); end
    checks++;
    if (first_rd_valid !== 1'b1 || first_rd_addr !== 32'h0 || first_rd_data !== 32'h13) begin
      errors++; $display("FAIL first_rd got v=%0b a=%0h d=%0h want 1 0 13",
                         first_rd_valid, first_rd_addr, first_rd_data);
    end
    checks++;
    if (wd_state !== 2'd1 || err_valid !== 1'b0) begin
      errors++; $display("FAIL single_rd_state wd=%0d err=%0b want 1 0", wd_state, err_valid);
    end
    // A second read must leave the first capture alone.
    bus.mon_arvalid = 1; bus.mon_arready = 1; bus.mon_araddr = 32'h40;
    step();
    bus.mon_arvalid = 0; bus.mon_arready = 0;
    bus.mon_rvalid = 1; bus.mon_rready = 1; bus.mon_rdata = 32'h55;
    step();
    bus.mon_rvalid = 0; bus.mon_rready = 0;
    checks++;
    if (rd_count !== 16'd2 || first_rd_addr !== 32'h0 || first_rd_data !== 32'h13) begin
      errors++; $display("FAIL second_rd cnt=%0d a=%0h d=%0h want 2 0 13",
                         rd_count, first_rd_addr, first_rd_data);
    end
  endtask

  task automatic test_unstable_ar();
    do_clr();
    bus.mon_arvalid = 1; bus.mon_arready = 0; bus.mon_araddr = 32'h100;
    step();
    checks++;
    if (err_valid !== 1'b0) begin errors++; $display("FAIL unstable_early err=%0b want 0", err_valid); end
    bus.mon_araddr = 32'h104;
    step();
    checks++;
    if (err_valid !== 1'b1 || err_code !== 3'd1) begin
      errors++; $display("FAIL unstable_ar code=%0d v=%0b want 1 1", err_code, err_valid);
    end
    bus.mon_arvalid = 0;
    bus.mon_rvalid = 1; bus.mon_rready = 1;
    step();
    bus.mon_rvalid = 0; bus.mon_rready = 0;
    checks++;
    if (err_code !== 3'd1) begin errors++; $display("FAIL unstable_sticky code=%0d want 1", err_code); end
  endtask

  task automatic test_orphan_simul();
    do_clr();
    bus.mon_rvalid = 1; bus.mon_rready = 1;
    step();
    bus.mon_rvalid = 0; bus.mon_rready = 0;
    checks++;
    if (err_code !== 3'd4 || dut.rd_out !== 4'd0) begin
      errors++; $display("FAIL r_orphan code=%0d out=%0d want 4 0", err_code, dut.rd_out);
    end
    do_clr();
    bus.mon_arvalid = 1; bus.mon_arready = 1;
    step();
    bus.mon_rvalid = 1; bus.mon_rready = 1;
    step();
    bus.mon_arvalid = 0; bus.mon_arready = 0;
    checks++;
    if (dut.rd_out !== 4'd1 || err_valid !== 1'b0) begin
      errors++; $display("FAIL simul_ar_r out=%0d err=%0b want 1 0", dut.rd_out, err_valid);
    end
    step();
    checks++;
    if (err_valid !== 1'b0) begin errors++; $display("FAIL r_drain err=%0b want 0", err_valid); end
    step();
    bus.mon_rvalid = 0; bus.mon_rready = 0;
    checks++;
    if (err_code !== 3'd4) begin errors++; $display("FAIL r_orphan2 code=%0d want 4", err_code); end
    do_clr();
    bus.mon_bvalid = 1; bus.mon_bready = 1;
    step();
    bus.mon_bvalid = 0; bus.mon_bready = 0;
    checks++;
    if (err_code !== 3'd5 || wr_count !== 16'd1) begin
      errors++; $display("FAIL b_orphan code=%0d wr=%0d want 5 1", err_code, wr_count);
    end
  endtask

  task automatic test_overflow();
    do_clr();
    bus.mon_arvalid = 1; bus.mon_arready = 1;
    for (int i = 0; i < 15; i++) begin
      bus.mon_araddr = 32'(i * 4);
      step();
    end
    checks++;
    if (err_valid !== 1'b0 || dut.rd_out !== 4'd15) begin
      errors++; $display("FAIL ovf_pre err=%0b out=%0d want 0 15", err_valid, dut.rd_out);
    end
    step();
    bus.mon_arvalid = 0; bus.mon_arready = 0;
    checks++;
    if (err_code !== 3'd6 || dut.rd_out !== 4'd15) begin
      errors++; $display("FAIL ovf code=%0d out=%0d want 6 15", err_code, dut.rd_out);
    end
  endtask

  task automatic test_stall();
    do_clr();
    bus.mon_awvalid = 1; bus.mon_awready = 0; bus.mon_awaddr = 32'h200;
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (err_valid !== 1'b0) begin errors++; $display("FAIL stall_early err=%0b want 0", err_valid); end
    step();
    checks++;
    if (err_code !== 3'd7) begin errors++; $display("FAIL stall code=%0d want 7", err_code); end
    bus.mon_awready = 1;
    step();
    bus.mon_awvalid = 0; bus.mon_awready = 0;
  endtask

  task automatic test_watchdog();
    idle_bus();
    do_reset();
    for (int i = 0; i < 99; i++) step();
    checks++;
    if (timeout !== 1'b0 || wd_state !== 2'd0) begin
      errors++; $display("FAIL wd_99 to=%0b wd=%0d want 0 0", timeout, wd_state);
    end
    step();
    checks++;
    if (timeout !== 1'b1 || wd_state !== 2'd2) begin
      errors++; $display("FAIL wd_100 to=%0b wd=%0d want 1 2", timeout, wd_state);
    end
    do_reset();
    for (int i = 0; i < 99; i++) step();
    bus.mon_arvalid = 1; bus.mon_arready = 1;
    step();
    bus.mon_arvalid = 0; bus.mon_arready = 0;
    checks++;
    if (timeout !== 1'b0 || wd_state !== 2'd1) begin
      errors++; $display("FAIL wd_restart to=%0b wd=%0d want 0 1", timeout, wd_state);
    end
    for (int i = 0; i < 99; i++) step();
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL wd_re99 to=%0b want 0", timeout); end
    step();
    checks++;
    if (timeout !== 1'b1 || wd_state !== 2'd2) begin
      errors++; $display("FAIL wd_re100 to=%0b wd=%0d want 1 2", timeout, wd_state);
    end
  endtask

  task automatic test_trap();
    idle_bus();
    do_reset();
    for (int i = 0; i < 500; i++) step();
    checks++;
    if (trap_seen !== 1'b0) begin errors++; $display("FAIL trap_early seen=%0b want 0", trap_seen); end
    cpu_trap = 1;
    step();
    cpu_trap = 0;
    checks++;
    if (trap_seen !== 1'b1 || trap_cycle !== 32'd500) begin
      errors++; $display("FAIL trap seen=%0b cyc=%0d want 1 500", trap_seen, trap_cycle);
    end
    step(); cpu_trap = 1; step(); cpu_trap = 0;
    checks++;
    if (trap_cycle !== 32'd500) begin errors++; $display("FAIL trap_hold cyc=%0d want 500", trap_cycle); end
    do_clr();
    checks++;
    if (trap_seen !== 1'b0 || trap_cycle !== 32'd0 || timeout !== 1'b0 || wd_state !== 2'd0) begin
      errors++; $display("FAIL clr_state seen=%0b cyc=%0d to=%0b wd=%0d want 0 0 0 0",
                         trap_seen, trap_cycle, timeout, wd_state);
    end
  endtask

  task automatic test_reset_mid();
    bus.mon_arvalid = 1; bus.mon_arready = 1; bus.mon_araddr = 32'hABC;
    step();
    bus.mon_rvalid = 1; bus.mon_rready = 1; bus.mon_rdata = 32'h77;
    bus.mon_araddr = 32'hAC0;
    cpu_trap = 1;
    step();
    bus.mon_arready = 0;
    areset = 1;
    #2;
    checks++;
    if ({rd_count, wr_count, first_rd_valid, first_rd_addr, first_rd_data, trap_seen,
         trap_cycle, err_valid, err_code, timeout, wd_state} !== '0) begin
      errors++; $display("FAIL reset_mid rd=%0d a=%0h trap=%0b wd=%0d want all zero",
                         rd_count, first_rd_addr, trap_seen, wd_state);
    end
    idle_bus();
    #2 areset = 0;
    step();
  endtask

  // Reference model state, advanced once per sampled edge from the driven inputs.
  int          m_rd_cnt, m_wr_cnt, m_rd_out, m_wr_out, m_idle, m_wd, m_code;
  int          m_run [3];
  bit          m_ar_seen, m_first_v, m_err_v;
  logic [31:0] m_first_addr, m_first_data;

  task automatic test_random();
    for (int round = 0; round < 3; round++) begin
      idle_bus();
      do_clr();
      m_rd_cnt = 0; m_wr_cnt = 0; m_rd_out = 0; m_wr_out = 0; m_idle = 0; m_wd = 0; m_code = 0;
      m_run = '{0, 0, 0}; m_ar_seen = 0; m_first_v = 0; m_err_v = 0;
      m_first_addr = '0; m_first_data = '0;
      for (int cyc = 0; cyc < 150; cyc++) begin
        bit ar, r, aw, w, b, stalled;
        int cand, nr, nw;
        ar = bus.mon_arvalid && bus.mon_arready;
        r  = bus.mon_rvalid  && bus.mon_rready;
        aw = bus.mon_awvalid && bus.mon_awready;
        w  = bus.mon_wvalid  && bus.mon_wready;
        b  = bus.mon_bvalid  && bus.mon_bready;
        cand = 0;
        m_run[0] = (bus.mon_arvalid && !bus.mon_arready) ? m_run[0] + 1 : 0;
        m_run[1] = (bus.mon_awvalid && !bus.mon_awready) ? m_run[1] + 1 : 0;
        m_run[2] = (bus.mon_wvalid  && !bus.mon_wready)  ? m_run[2] + 1 : 0;
        stalled = (m_run[0] >= 8) || (m_run[1] >= 8) || (m_run[2] >= 8);
        nr = m_rd_out + int'(ar) - int'(r);
        nw = m_wr_out + int'(aw) - int'(b);
        if (stalled) cand = 7;
        if (nr > 15 || nw > 15) cand = 6;
        if (nw < 0) cand = 5;
        if (nr < 0) cand = 4;
        if (nr >= 0 && nr <= 15) m_rd_out = nr;
        if (nw >= 0 && nw <= 15) m_wr_out = nw;
        if (r && m_rd_cnt < 65535) m_rd_cnt++;
        if (b && m_wr_cnt < 65535) m_wr_cnt++;
        if (ar && !m_ar_seen) begin m_ar_seen = 1; m_first_addr = bus.mon_araddr; end
        if (r && !m_first_v) begin m_first_v = 1; m_first_data = bus.mon_rdata; end
        if (!m_err_v && cand != 0) begin m_err_v = 1; m_code = cand; end
        if (m_wd != 2) begin
          if (ar || r || aw || w || b) begin m_idle = 0; m_wd = 1; end
          else begin m_idle++; if (m_idle == 100) m_wd = 2; end
        end
        step();
        checks++;
        if (rd_count !== 16'(m_rd_cnt) || wr_count !== 16'(m_wr_cnt)) begin
          errors++; $display("FAIL rand_counts cyc=%0d rd=%0d wr=%0d want %0d %0d",
                             cyc, rd_count, wr_count, m_rd_cnt, m_wr_cnt);
        end
        checks++;
        if (err_valid !== m_err_v || err_code !== 3'(m_code)) begin
          errors++; $display("FAIL rand_err cyc=%0d v=%0b code=%0d want %0b %0d",
                             cyc, err_valid, err_code, m_err_v, m_code);
        end
        checks++;
        if (wd_state !== 2'(m_wd) || timeout !== (m_wd == 2)) begin
          errors++; $display("FAIL rand_wd cyc=%0d wd=%0d want %0d", cyc, wd_state, m_wd);
        end
        checks++;
        if (first_rd_valid !== m_first_v || first_rd_addr !== m_first_addr ||
            first_rd_data !== m_first_data) begin
          errors++; $display("FAIL rand_first cyc=%0d v=%0b a=%0h d=%0h want %0b %0h %0h", cyc,
                             first_rd_valid, first_rd_addr, first_rd_data,
                             m_first_v, m_first_addr, m_first_data);
        end
        // Next inputs: a stalled AR/AW/W keeps its valid and payload.
        if (!(bus.mon_arvalid && !bus.mon_arready)) begin
          bus.mon_arvalid = ($urandom_range(0, 3) == 0); bus.mon_araddr = $urandom;
        end
        if (!(bus.mon_awvalid && !bus.mon_awready)) begin
          bus.mon_awvalid = ($urandom_range(0, 3) == 0); bus.mon_awaddr = $urandom;
        end
        if (!(bus.mon_wvalid && !bus.mon_wready)) begin
          bus.mon_wvalid = ($urandom_range(0, 3) == 0); bus.mon_wdata = $urandom;
        end
        bus.mon_arready = 1'($urandom_range(0, 1));
        bus.mon_awready = 1'($urandom_range(0, 1));
        bus.mon_wready  = 1'($urandom_range(0, 1));
        bus.mon_rvalid  = ($urandom_range(0, 4) == 0);
        bus.mon_rready  = 1'($urandom_range(0, 1));
        bus.mon_rdata   = $urandom;
        bus.mon_bvalid  = ($urandom_range(0, 4) == 0);
        bus.mon_bready  = 1'($urandom_range(0, 1));
      end
    end
    idle_bus();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_unstable_ar();
    test_orphan_simul();
    test_overflow();
    test_stall();
    test_watchdog();
    test_trap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
